// File: rtl/timer_pkg.sv
// Shared definitions for the parametrised timer: state encoding,
// default thresholds and the legal counter-width range.
package timer_pkg;

    // Progress of the counter relative to the two thresholds.
    typedef enum logic [1:0] {
        CLEARED   = 2'd0,
        COUNTING  = 2'd1,
        SHORT_HIT = 2'd2,
        LONG_HIT  = 2'd3
    } timer_state_e;

    // Thresholds loaded on reset when the instance does not override them.
    localparam int SHORT_DEF_C = 3;
    localparam int LONG_DEF_C  = 7;

    // Legal range for the counter / threshold width.
    localparam int CNT_W_MIN = 2;
    localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for param_timer: one-cycle tick every PRESC enabled cycles.
// Restarts on clr, freezes while hold is high. Only instantiated when
// TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int DIV_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESC - 1);

    logic [DIV_W-1:0] div_q;

    // The tick lands on the last phase, so the first tick after a clear
    // appears PRESC cycles later.
    assign tick = (div_q == DIV_LAST);

    // Phase counter: restart on clear, freeze on hold, wrap after the last phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (clr) begin
            div_q <= '0;
        end else if (!hold) begin
            if (tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/param_timer.sv
// param_timer: saturating up-counter with runtime-programmable short/long
// thresholds, hold, timeout levels and edge pulses, and a config-error flag.
// Optional feature macro: TIMER_PRESCALE_EN (tick from a PRESC-cycle divider;
// otherwise the counter ticks every cycle and PRESC is ignored).
module param_timer
    import timer_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int SHORT_DEF = SHORT_DEF_C,
    parameter int LONG_DEF  = LONG_DEF_C,
    parameter int PRESC     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_hw_reset,
    input  logic             timer_fw_reset,
    input  logic             hold,
    input  logic             thr_load,
    input  logic [CNT_W-1:0] short_thr,
    input  logic [CNT_W-1:0] long_thr,
    output logic [CNT_W-1:0] count,
    output logic             short_timeout,
    output logic             long_timeout,
    output logic             short_pulse,
    output logic             long_pulse,
    output logic             cfg_err
);

    // Reject illegal parameter sets at elaboration.
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX || SHORT_DEF < 0 ||
        SHORT_DEF > LONG_DEF || LONG_DEF > (2 ** CNT_W) - 1 || PRESC < 1) begin : g_bad_cfg
        $error("param_timer: illegal parameter combination");
    end

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] short_thr_q;
    logic [CNT_W-1:0] long_thr_q;
    timer_state_e     state_q;
    timer_state_e     state_nxt;
    logic             short_to_q;
    logic             long_to_q;
    logic             cfg_err_q;
    logic             thr_valid;
    logic             load_ok;
    logic             load_bad;
    logic             clr;
    logic             tick;

    // Classify a counter value against the thresholds; the long check comes
    // first so hitting both at once lands directly in LONG_HIT.
    function automatic timer_state_e classify(input logic [CNT_W-1:0] c,
                                              input logic [CNT_W-1:0] s_thr,
                                              input logic [CNT_W-1:0] l_thr);
        if (c >= l_thr) begin
            return LONG_HIT;
        end else if (c >= s_thr) begin
            return SHORT_HIT;
        end else begin
            return COUNTING;
        end
    endfunction

    assign thr_valid = (short_thr <= long_thr);
    assign load_ok   = thr_load & thr_valid;
    assign load_bad  = thr_load & ~thr_valid;
    assign clr       = timer_hw_reset | timer_fw_reset | load_ok;

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESC (PRESC)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .hold  (hold),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Counter next value: clear beats hold, hold beats tick, saturate at long.
    always_comb begin
        count_nxt = count_q;
        if (clr) begin
            count_nxt = '0;
        end else if (!hold && tick && (count_q < long_thr_q)) begin
            count_nxt = count_q + CNT_W'(1);
        end
    end

    // State next value follows the counter; LONG_HIT is sticky until a clear.
    always_comb begin
        state_nxt = state_q;
        if (clr) begin
            state_nxt = CLEARED;
        end else if (!hold && tick) begin
            case (state_q)
                LONG_HIT: state_nxt = LONG_HIT;
                default:  state_nxt = classify(count_nxt, short_thr_q, long_thr_q);
            endcase
        end
    end

    // Counter, state and thresholds; a valid load also clears via clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            state_q     <= CLEARED;
            short_thr_q <= CNT_W'(SHORT_DEF);
            long_thr_q  <= CNT_W'(LONG_DEF);
        end else begin
            count_q <= count_nxt;
            state_q <= state_nxt;
            if (load_ok) begin
                short_thr_q <= short_thr;
                long_thr_q  <= long_thr;
            end
        end
    end

    // Timeout history for edge detection, plus the rejected-load flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            short_to_q <= 1'b0;
            long_to_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            short_to_q <= short_timeout;
            long_to_q  <= long_timeout;
            cfg_err_q  <= load_bad;
        end
    end

    assign count         = count_q;
    assign short_timeout = (count_q >= short_thr_q);
    assign long_timeout  = (count_q >= long_thr_q);
    // Pulses are held low while reset is asserted; with a zero threshold the
    // level is already high in reset, and the pulse then shows in the first
    // cycle after release because the history starts at zero.
    assign short_pulse   = reset & short_timeout & ~short_to_q;
    assign long_pulse    = reset & long_timeout & ~long_to_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_param_timer.sv
// Directed bench for param_timer in its default build (CNT_W=3, thresholds
// 3/7, tick every cycle).
module tb_param_timer;

    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             timer_hw_reset;
    logic             timer_fw_reset;
    logic             hold;
    logic             thr_load;
    logic [CNT_W-1:0] short_thr;
    logic [CNT_W-1:0] long_thr;
    logic [CNT_W-1:0] count;
    logic             short_timeout;
    logic             long_timeout;
    logic             short_pulse;
    logic             long_pulse;
    logic             cfg_err;

    int checks;
    int errors;

    param_timer #(
        .CNT_W     (CNT_W),
        .SHORT_DEF (3),
        .LONG_DEF  (7),
        .PRESC     (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .timer_hw_reset (timer_hw_reset),
        .timer_fw_reset (timer_fw_reset),
        .hold           (hold),
        .thr_load       (thr_load),
        .short_thr      (short_thr),
        .long_thr       (long_thr),
        .count          (count),
        .short_timeout  (short_timeout),
        .long_timeout   (long_timeout),
        .short_pulse    (short_pulse),
        .long_pulse     (long_pulse),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Check every output against one expected vector.
    task automatic chk_all(input string tag, input int c, input int st, input int lt,
                           input int sp, input int lp, input int ce);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".short_to"}, int'(short_timeout), st);
        chk({tag, ".long_to"}, int'(long_timeout), lt);
        chk({tag, ".short_pulse"}, int'(short_pulse), sp);
        chk({tag, ".long_pulse"}, int'(long_pulse), lp);
        chk({tag, ".cfg_err"}, int'(cfg_err), ce);
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fw_clear();
        timer_fw_reset = 1'b1;
        step();
        timer_fw_reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset          = 1'b0;
        timer_hw_reset = 1'b0;
        timer_fw_reset = 1'b0;
        hold           = 1'b0;
        thr_load       = 1'b0;
        short_thr      = '0;
        long_thr       = '0;

        // Reset state
        step();
        step();
        chk_all("rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("rel", 0, 0, 0, 0, 0, 0);

        // Free run from reset: 1..7 then saturate
        for (int n = 1; n <= 9; n++) begin
            int c;
            c = (n < 7) ? n : 7;
            step();
            chk_all($sformatf("run%0d", n), c, int'(c >= 3), int'(c >= 7),
                    int'(n == 3), int'(n == 7), 0);
        end

        // Firmware clear from LONG_HIT: levels drop, no falling pulses
        fw_clear();
        chk_all("fwclr", 0, 0, 0, 0, 0, 0);

        // HW clear at count 5, then recount to short
        repeat (5) step();
        chk("pre_hw.count", int'(count), 5);
        timer_hw_reset = 1'b1;
        step();
        timer_hw_reset = 1'b0;
        chk_all("hwclr", 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_all("hw_re2", 2, 0, 0, 0, 0, 0);
        step();
        chk_all("hw_re3", 3, 1, 0, 1, 0, 0);

        // Hold for 4 cycles at count 2
        fw_clear();
        step();
        step();
        chk("pre_hold.count", int'(count), 2);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all($sformatf("hold%0d", i), 2, 0, 0, 0, 0, 0);
        end
        hold = 1'b0;
        step();
        chk_all("post_hold", 3, 1, 0, 1, 0, 0);

        // Valid load 2/2 at count 6: clears, both pulses together
        fw_clear();
        repeat (6) step();
        chk("pre_load.count", int'(count), 6);
        thr_load  = 1'b1;
        short_thr = 3'd2;
        long_thr  = 3'd2;
        step();
        thr_load = 1'b0;
        chk_all("ld22_0", 0, 0, 0, 0, 0, 0);
        step();
        chk_all("ld22_1", 1, 0, 0, 0, 0, 0);
        step();
        chk_all("ld22_2", 2, 1, 1, 1, 1, 0);
        step();
        chk_all("ld22_sat", 2, 1, 1, 0, 0, 0);

        // Restore 3/7, then an invalid 5/4 load at count 2
        thr_load  = 1'b1;
        short_thr = 3'd3;
        long_thr  = 3'd7;
        step();
        thr_load = 1'b0;
        chk_all("ld37", 0, 0, 0, 0, 0, 0);
        step();
        step();
        thr_load  = 1'b1;
        short_thr = 3'd5;
        long_thr  = 3'd4;
        step();
        thr_load = 1'b0;
        chk_all("bad_ld", 3, 1, 0, 1, 0, 1);
        step();
        chk_all("bad_ld1", 4, 1, 0, 0, 0, 0);
        repeat (3) step();
        chk_all("bad_ld_long", 7, 1, 1, 0, 1, 0);

        // Async reset mid-operation takes effect without a clock edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        chk_all("after_rst", 3, 1, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
